// File: rtl/aes_decipher_iter_if.sv
// aes_decipher_iter_if: control/API and key-memory bundle for the iterative
// AES decipher datapath. The master side owns the start pulse, ciphertext and
// the round-key memory read data; the slave (the datapath) owns the key
// address, the working state and the ready flag.
interface aes_decipher_iter_if;
    logic         next;
    logic         keylen;
    logic [3:0]   round_key_addr;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    modport master (
        output next, keylen, round_key, block,
        input  round_key_addr, new_block, ready
    );

    modport slave (
        input  next, keylen, round_key, block,
        output round_key_addr, new_block, ready
    );
endinterface

// File: rtl/aes_decipher_iter.sv
// aes_decipher_iter: iterative AES InvCipher (AES-128 / AES-256) with its own
// round sequencer. One round is SHIFT, then 4/NUM_SBOX_WORDS SUB cycles, then
// KEYMIX; round keys are fetched combinationally through the bus address port.
// State byte i (column-major) sits at state[127-8*i -: 8].
module aes_decipher_iter #(
    parameter int NUM_SBOX_WORDS = 4,
    parameter bit SUPPORT_256    = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    aes_decipher_iter_if.slave bus
);

    if (!(NUM_SBOX_WORDS == 1 || NUM_SBOX_WORDS == 2 || NUM_SBOX_WORDS == 4)) begin : g_bad_param
        $error("aes_decipher_iter: NUM_SBOX_WORDS must be 1, 2 or 4");
    end

    // Step of the S-box word pointer and its value on the last SUB cycle;
    // with four lanes both wrap to 0 so SUB lasts a single cycle.
    localparam logic [1:0] SW_STEP = 2'(NUM_SBOX_WORDS);
    localparam logic [1:0] SW_LAST = 2'(4 - NUM_SBOX_WORDS);

    typedef enum logic [2:0] {IDLE, INIT, SHIFT, SUB, KEYMIX} state_e;

    // ------------------------------------------------------------------
    // GF(2^8) helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse S-box: undo the affine map, then multiplicative inverse as a^254
    // (maps 0 to 0 as the AES S-box requires).
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] a;
        logic [7:0] r;
        a = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, a);
        end
        return r;
    endfunction

    // Row r of the result takes column (c - r) mod 4 of the input.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r)&3)+r) -: 8];
            end
        end
        return o;
    endfunction

    // One column of InvMixColumns; 09/0b/0d/0e built from an xtime chain.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = w[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        return o;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e       fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   round_ctr_q, round_ctr_d;
    logic [1:0]   sword_ctr_q, sword_ctr_d;
    logic         ready_q, ready_d;

    logic [3:0]   nr_in;
    logic [127:0] addkey;

    assign nr_in  = (SUPPORT_256 && bus.keylen) ? 4'd14 : 4'd10;
    assign addkey = state_q ^ bus.round_key;

    // ------------------------------------------------------------------
    // Inverse S-box lanes: lane k works on column sword_ctr + k.
    // Column c lives in st_w[3-c] (column 0 is the most significant word).
    // ------------------------------------------------------------------
    logic [3:0][31:0]                st_w, sub_w;
    logic [NUM_SBOX_WORDS-1:0][1:0]  lane_col;
    logic [NUM_SBOX_WORDS-1:0][31:0] lane_in, lane_out;

    assign st_w = state_q;

    for (genvar k = 0; k < NUM_SBOX_WORDS; k++) begin : g_lane
        assign lane_col[k] = sword_ctr_q + 2'(k);
        assign lane_in[k]  = st_w[2'd3 - lane_col[k]];
        for (genvar b = 0; b < 4; b++) begin : g_byte
            assign lane_out[k][8*b +: 8] = inv_sbox(lane_in[k][8*b +: 8]);
        end
    end

    // Merge the substituted columns back into the working state.
    always_comb begin
        sub_w = st_w;
        for (int k = 0; k < NUM_SBOX_WORDS; k++) sub_w[2'd3 - lane_col[k]] = lane_out[k];
    end

    // Sequencer: next state and datapath updates.
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        round_ctr_d = round_ctr_q;
        sword_ctr_d = sword_ctr_q;
        ready_d     = ready_q;
        case (fsm_q)
            IDLE: begin
                if (bus.next) begin
                    state_d     = bus.block;
                    round_ctr_d = nr_in;
                    ready_d     = 1'b0;
                    fsm_d       = INIT;
                end
            end
            INIT: begin
                state_d     = addkey;
                round_ctr_d = round_ctr_q - 4'd1;
                fsm_d       = SHIFT;
            end
            SHIFT: begin
                state_d     = inv_shift_rows(state_q);
                sword_ctr_d = 2'd0;
                fsm_d       = SUB;
            end
            SUB: begin
                state_d     = sub_w;
                sword_ctr_d = sword_ctr_q + SW_STEP;
                if (sword_ctr_q == SW_LAST) fsm_d = KEYMIX;
            end
            KEYMIX: begin
                if (round_ctr_q != 4'd0) begin
                    state_d     = inv_mix_columns(addkey);
                    round_ctr_d = round_ctr_q - 4'd1;
                    fsm_d       = SHIFT;
                end else begin
                    state_d = addkey;
                    ready_d = 1'b1;
                    fsm_d   = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State registers with asynchronous abort on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            round_ctr_q <= 4'd0;
            sword_ctr_q <= 2'd0;
            ready_q     <= 1'b1;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            round_ctr_q <= round_ctr_d;
            sword_ctr_q <= sword_ctr_d;
            ready_q     <= ready_d;
        end
    end

    // Key address: Nr of the pending keylen while idle so the first key is
    // already being fetched, round counter otherwise; held at 0 during reset.
    always_comb begin
        if (reset)              bus.round_key_addr = 4'd0;
        else if (fsm_q == IDLE) bus.round_key_addr = nr_in;
        else                    bus.round_key_addr = round_ctr_q;
    end

    assign bus.new_block = state_q;
    assign bus.ready     = ready_q;

endmodule

// File: tb/tb_aes_decipher_iter.sv
// tb_aes_decipher_iter: directed FIPS-197 vectors run in parallel on four
// configurations: N=4, N=2, N=1 (AES-256 capable) and N=4 AES-128 only.
// Round keys come from a key expansion computed here from the cipher keys.
module tb_aes_decipher_iter;

    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset;
    logic         next, keylen, rec;
    logic [127:0] block;
    logic [127:0] rk128 [16];
    logic [127:0] rk256 [16];
    int           n_cmp = 0;
    int           n_err = 0;
    int           lat [4];
    logic [3:0]   addr_q [$];

    always #5 clk = ~clk;

    aes_decipher_iter_if bus4 ();
    aes_decipher_iter_if bus2 ();
    aes_decipher_iter_if bus1 ();
    aes_decipher_iter_if bus0 ();

    assign bus4.next = next;  assign bus4.keylen = keylen;  assign bus4.block = block;
    assign bus2.next = next;  assign bus2.keylen = keylen;  assign bus2.block = block;
    assign bus1.next = next;  assign bus1.keylen = keylen;  assign bus1.block = block;
    assign bus0.next = next;  assign bus0.keylen = keylen;  assign bus0.block = block;
    assign bus4.round_key = keylen ? rk256[bus4.round_key_addr] : rk128[bus4.round_key_addr];
    assign bus2.round_key = keylen ? rk256[bus2.round_key_addr] : rk128[bus2.round_key_addr];
    assign bus1.round_key = keylen ? rk256[bus1.round_key_addr] : rk128[bus1.round_key_addr];
    assign bus0.round_key = rk128[bus0.round_key_addr];

    aes_decipher_iter #(.NUM_SBOX_WORDS(4), .SUPPORT_256(1'b1)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    aes_decipher_iter #(.NUM_SBOX_WORDS(2), .SUPPORT_256(1'b1)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    aes_decipher_iter #(.NUM_SBOX_WORDS(1), .SUPPORT_256(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    aes_decipher_iter #(.NUM_SBOX_WORDS(4), .SUPPORT_256(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    logic [3:0]   rdy;
    logic [127:0] nb [4];
    assign rdy   = {bus0.ready, bus1.ready, bus2.ready, bus4.ready};
    assign nb[0] = bus4.new_block;
    assign nb[1] = bus2.new_block;
    assign nb[2] = bus1.new_block;
    assign nb[3] = bus0.new_block;

    // Distinct key addresses of dut4 while busy, collapsed over repeats.
    always @(negedge clk) begin
        if (!rec) addr_q.delete();
        else if (!bus4.ready && (addr_q.size() == 0 || addr_q[$] != bus4.round_key_addr))
            addr_q.push_back(bus4.round_key_addr);
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            v = gm(v, v);
            if (i != 0) v = gm(v, b);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Key schedule; key is left-aligned, nk = 4 or 8 words.
    task automatic expand(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            if (nk == 4) rk128[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk256[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One operation on all four DUTs; lat[d] = edges from accept to ready.
    // With poke, next is pulsed mid-op and during dut4's ready-rise edge.
    task automatic run_op(input logic kl, input logic [127:0] blk, input bit poke);
        bit done [4];
        @(negedge clk);
        keylen = kl;
        block  = blk;
        next   = 1'b1;
        @(negedge clk);
        next = 1'b0;
        for (int d = 0; d < 4; d++) begin
            lat[d]  = -1;
            done[d] = 1'b0;
        end
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 4; d++) begin
                if (!done[d] && rdy[d]) begin
                    lat[d]  = cyc;
                    done[d] = 1'b1;
                end
            end
            if (poke) begin
                if (cyc == 5)  begin next = 1'b1; block = ~blk; end
                if (cyc == 6)  next = 1'b0;
                if (cyc == 30) next = 1'b1;
                if (cyc == 31) next = 1'b0;
                if (cyc == 32) chk("t4_rise_next_ignored", 128'(rdy[0]), 128'd1);
            end
            if (done[0] && done[1] && done[2] && done[3]) break;
        end
    endtask

    initial begin
        logic [59:0] seq;
        reset  = 1'b1;
        next   = 1'b0;
        keylen = 1'b0;
        block  = '0;
        rec    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rk128[i] = '0;
            rk256[i] = '0;
        end
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ready", 128'(rdy[0]), 128'd1);
        chk("rst_new_block", nb[0], 128'd0);
        chk("rst_addr", 128'(bus4.round_key_addr), 128'd0);
        reset = 1'b0;
        #1;
        chk("idle_addr_k128", 128'(bus4.round_key_addr), 128'd10);
        keylen = 1'b1;
        #1;
        chk("idle_addr_k256", 128'(bus4.round_key_addr), 128'd14);
        chk("idle_addr_s0_k256", 128'(bus0.round_key_addr), 128'd10);

        // AES-128 C.1 on all configurations
        run_op(1'b0, C1_CT, 1'b0);
        chk("t1_pt_n4", nb[0], PT);
        chk("t1_pt_n2", nb[1], PT);
        chk("t1_pt_n1", nb[2], PT);
        chk("t1_pt_s0", nb[3], PT);
        chk("t1_lat_n4", 128'(lat[0]), 128'd31);
        chk("t1_lat_n2", 128'(lat[1]), 128'd41);
        chk("t1_lat_n1", 128'(lat[2]), 128'd61);
        chk("t1_lat_s0", 128'(lat[3]), 128'd31);

        // AES-256 C.3, with the key address sequence of dut4
        rec = 1'b1;
        run_op(1'b1, C3_CT, 1'b0);
        rec = 1'b0;
        chk("t2_pt_n4", nb[0], PT);
        chk("t2_pt_n2", nb[1], PT);
        chk("t2_pt_n1", nb[2], PT);
        chk("t2_lat_n4", 128'(lat[0]), 128'd43);
        chk("t2_lat_n2", 128'(lat[1]), 128'd57);
        chk("t2_lat_n1", 128'(lat[2]), 128'd85);
        chk("t2_lat_s0", 128'(lat[3]), 128'd31);
        seq = '0;
        foreach (addr_q[i]) seq = {seq[55:0], addr_q[i]};
        chk("t2_addr_count", 128'(addr_q.size()), 128'd15);
        chk("t2_addr_seq", 128'(seq), 128'(60'hedcba9876543210));

        // next while busy / in ready-rise cycle, block changed mid-op
        run_op(1'b0, C1_CT, 1'b1);
        chk("t4_pt_n4", nb[0], PT);
        chk("t4_pt_n1", nb[2], PT);
        chk("t4_lat_n4", 128'(lat[0]), 128'd31);
        chk("t4_lat_n1", 128'(lat[2]), 128'd61);
        run_op(1'b1, C3_CT, 1'b0);
        chk("t4_b2b_k256_n4", nb[0], PT);
        chk("t4_b2b_k256_n2", nb[1], PT);

        // Reset part-way through an op
        @(negedge clk);
        keylen = 1'b0;
        block  = C1_CT;
        next   = 1'b1;
        @(negedge clk);
        next = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("t5_busy_before_rst", 128'(rdy[0]), 128'd0);
        reset = 1'b1;
        #1;
        chk("t5_rst_ready_n4", 128'(rdy[0]), 128'd1);
        chk("t5_rst_nb_n4", nb[0], 128'd0);
        chk("t5_rst_ready_n1", 128'(rdy[2]), 128'd1);
        chk("t5_rst_nb_n1", nb[2], 128'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(1'b0, C1_CT, 1'b0);
        chk("t5_after_pt_n4", nb[0], PT);
        chk("t5_after_lat_n4", 128'(lat[0]), 128'd31);

        // AES-128-only build ignores keylen
        run_op(1'b1, C1_CT, 1'b0);
        chk("t6_pt_s0", nb[3], PT);
        chk("t6_lat_s0", 128'(lat[3]), 128'd31);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_hold_pt_s0", nb[3], PT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
